// File: rtl/la_rrarbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : la_rrarbiter_if
// Brief    : Request/grant bundle between N requesters and la_rrarbiter.
// Revision : 1.0
// ============================================================================
interface la_rrarbiter_if #(
  parameter int N = 4
);
  localparam int c_IW = (N > 2) ? $clog2(N) : 1;

  logic [N-1:0]    req;
  logic [N-1:0]    gnt;
  logic            gnt_valid;
  logic [c_IW-1:0] gnt_id;

  modport master (output req, input gnt, input gnt_valid, input gnt_id);
  modport slave  (input req, output gnt, output gnt_valid, output gnt_id);
endinterface
`default_nettype wire

// File: rtl/la_rrarbiter.sv
`default_nettype none
// ============================================================================
// Module   : la_rrarbiter
// Brief    : Registered round-robin arbiter with burst hold; define
//            LA_RRARBITER_TIMEOUT_EN to force rotation after MAXCYC cycles.
// Revision : 1.0
// ============================================================================
module la_rrarbiter #(
  parameter int N      = 4,
  parameter int MAXCYC = 16,
  parameter     PROP   = "DEFAULT"
) (
  input logic          clk,
  input logic          reset,
  la_rrarbiter_if.slave arb
);
  localparam int c_IW = (N > 2) ? $clog2(N) : 1;
  localparam int c_SW = c_IW + 1;

  if (N < 2 || N > 32) begin : g_bad_n
    $error("la_rrarbiter: N out of range");
  end
  if (MAXCYC < 2 || MAXCYC > 65535) begin : g_bad_maxcyc
    $error("la_rrarbiter: MAXCYC out of range");
  end
  if ($bits(PROP) == 0) begin : g_bad_prop
    $error("la_rrarbiter: PROP must not be empty");
  end

  logic [N-1:0]    r_gnt;
  logic            r_valid;
  logic [c_IW-1:0] r_id;
  logic [c_IW-1:0] r_ptr;

  logic            w_expire;
  logic            w_hold;
  logic            w_found;
  logic [N-1:0]    w_cand;
  logic [c_IW-1:0] w_sel;
  logic [c_IW-1:0] w_ptr_nxt;
  logic [c_SW-1:0] w_sum;

  assign w_hold = r_valid && arb.req[r_id] && !w_expire;
  // On a forced rotation the current holder sits out this selection.
  assign w_cand = w_expire ? (arb.req & ~r_gnt) : arb.req;

  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_sum   = '0;
    for (int i = 0; i < N; i++) begin
      w_sum = {1'b0, r_ptr} + c_SW'(i);
      if (w_sum >= c_SW'(N)) begin
        w_sum = w_sum - c_SW'(N);
      end
      if (!w_found && w_cand[w_sum[c_IW-1:0]]) begin
        w_found = 1'b1;
        w_sel   = w_sum[c_IW-1:0];
      end
    end
  end

  assign w_ptr_nxt = (w_sel == c_IW'(N - 1)) ? '0 : w_sel + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_gnt   <= '0;
      r_valid <= 1'b0;
      r_id    <= '0;
      r_ptr   <= '0;
    end else if (w_hold) begin
      r_gnt   <= r_gnt;
    end else if (w_found) begin
      r_gnt        <= '0;
      r_gnt[w_sel] <= 1'b1;
      r_valid      <= 1'b1;
      r_id         <= w_sel;
      r_ptr        <= w_ptr_nxt;
    end else begin
      r_gnt   <= '0;
      r_valid <= 1'b0;
      r_id    <= '0;
    end
  end

`ifdef LA_RRARBITER_TIMEOUT_EN
  localparam int c_CW = $clog2(MAXCYC + 1);

  logic [c_CW-1:0] r_cnt;

  // Counter value k means the holder is in its (k+1)-th grant cycle.
  assign w_expire = r_valid && (r_cnt == c_CW'(MAXCYC - 1)) && (|(arb.req & ~r_gnt));

  always_ff @(posedge clk) begin
    if (reset || !w_hold) begin
      r_cnt <= '0;
    end else if (r_cnt != c_CW'(MAXCYC - 1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
`else
  assign w_expire = 1'b0;
`endif

  assign arb.gnt       = r_gnt;
  assign arb.gnt_valid = r_valid;
  assign arb.gnt_id    = r_id;
endmodule
`default_nettype wire
